// File: rtl/decode_sb_if.sv
// Fetch->decode, decode->execute and writeback bundle for decode_sb.
// slave = decode stage side, master = the surrounding pipeline / bench side.
interface decode_sb_if #(
    parameter int XLEN = 64
);
    logic [31:0]     fetch_insn;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_insn_valid;
    logic            fetch_retry;

    logic            decode_retry;
    logic            decode_valid;
    logic [31:0]     decode_insn;
    logic [XLEN-1:0] decode_pc;
    logic [XLEN-1:0] decode_sign_ext;
    logic [XLEN-1:0] decode_src1;
    logic [XLEN-1:0] decode_src2;

    logic            dest_valid;
    logic            dest_long;
    logic [4:0]      dest_rd;
    logic [XLEN-1:0] dest;

    modport slave (
        input  fetch_insn, fetch_pc, fetch_insn_valid, decode_retry,
        input  dest_valid, dest_long, dest_rd, dest,
        output fetch_retry, decode_valid, decode_insn, decode_pc,
        output decode_sign_ext, decode_src1, decode_src2
    );

    modport master (
        output fetch_insn, fetch_pc, fetch_insn_valid, decode_retry,
        output dest_valid, dest_long, dest_rd, dest,
        input  fetch_retry, decode_valid, decode_insn, decode_pc,
        input  decode_sign_ext, decode_src1, decode_src2
    );
endinterface

// File: rtl/decode_sb.sv
// Decode stage: register file, immediate extension, busy scoreboard and long-op limiter.
// Latency 1 cycle; fetch_retry on hazard or when execute stalls a valid output.
module decode_sb #(
    parameter int XLEN     = 64,
    parameter int MAX_LONG = 4,
    parameter int BYPASS   = 1
) (
    input  logic        clk,
    input  logic        reset,
    decode_sb_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    logic [31:0]     busy_q, busy_d;
    logic [3:0]      long_cnt_q, long_cnt_d;

    logic            dv_q, dv_d;
    logic [31:0]     insn_q, insn_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;

    logic [31:0]     insn;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic            writes_rd, uses_rs1, uses_rs2, is_long;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic            fwd1, fwd2, blk1, blk2, waw, long_hit, hazard;
    logic            wb_en, out_free, accept, inc, dec;
    logic [XLEN-1:0] op1, op2;

    // Instruction classification and immediate formation
    always_comb begin
        insn   = bus.fetch_insn;
        opcode = insn[6:0];
        rd     = insn[11:7];
        rs1    = insn[19:15];
        rs2    = insn[24:20];

        writes_rd = (opcode == OPC_LUI)   || (opcode == OPC_AUIPC) || (opcode == OPC_JAL)
                 || (opcode == OPC_JALR)  || (opcode == OPC_LOAD)  || (opcode == OPC_OPIMM)
                 || (opcode == OPC_OP)    || (opcode == OPC_OPIMMW) || (opcode == OPC_OPW);
        uses_rs1  = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
        uses_rs2  = (opcode == OPC_BRANCH) || (opcode == OPC_STORE)
                 || (opcode == OPC_OP)     || (opcode == OPC_OPW);
        is_long   = (opcode == OPC_LOAD)
                 || (((opcode == OPC_OP) || (opcode == OPC_OPW)) && (insn[31:25] == 7'b0000001));

        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_OPIMMW, OPC_JALR:
                imm32 = {{20{insn[31]}}, insn[31:20]};
            OPC_STORE:
                imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            OPC_BRANCH:
                imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {insn[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default:
                imm32 = 32'b0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // Hazards, operand read with optional writeback forwarding, handshake
    always_comb begin
        wb_en = bus.dest_valid && (bus.dest_rd != 5'd0);
        fwd1  = (BYPASS != 0) && bus.dest_valid && (bus.dest_rd == rs1);
        fwd2  = (BYPASS != 0) && bus.dest_valid && (bus.dest_rd == rs2);

        blk1     = uses_rs1 && (rs1 != 5'd0) && busy_q[rs1] && !fwd1;
        blk2     = uses_rs2 && (rs2 != 5'd0) && busy_q[rs2] && !fwd2;
        waw      = writes_rd && busy_q[rd] && !(bus.dest_valid && (bus.dest_rd == rd));
        long_hit = is_long && (long_cnt_q == 4'(MAX_LONG)) && !(bus.dest_valid && bus.dest_long);
        hazard   = blk1 || blk2 || waw || long_hit;

        out_free = !dv_q || !bus.decode_retry;
        accept   = bus.fetch_insn_valid && out_free && !hazard;

        if (rs1 == 5'd0)  op1 = '0;
        else if (fwd1)    op1 = bus.dest;
        else              op1 = regs_q[rs1];
        if (rs2 == 5'd0)  op2 = '0;
        else if (fwd2)    op2 = bus.dest;
        else              op2 = regs_q[rs2];
    end

    // Next state: output register, register file, scoreboard, long-op counter
    always_comb begin
        dv_d   = dv_q;
        insn_d = insn_q;
        pc_d   = pc_q;
        imm_d  = imm_q;
        src1_d = src1_q;
        src2_d = src2_q;
        if (accept) begin
            dv_d   = 1'b1;
            insn_d = insn;
            pc_d   = bus.fetch_pc;
            imm_d  = imm_ext;
            src1_d = op1;
            src2_d = op2;
        end else if (out_free) begin
            dv_d = 1'b0;
        end

        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_en) begin
            regs_d[bus.dest_rd] = bus.dest;
            busy_d[bus.dest_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue to the same rd keeps it busy
        if (accept && writes_rd && (rd != 5'd0))
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;

        inc        = accept && is_long;
        dec        = bus.dest_valid && bus.dest_long;
        long_cnt_d = long_cnt_q;
        if (inc && !dec)
            long_cnt_d = long_cnt_q + 4'd1;
        else if (dec && !inc && (long_cnt_q != 4'd0))
            long_cnt_d = long_cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            long_cnt_q <= '0;
            dv_q       <= 1'b0;
            insn_q     <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
        end else begin
            for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
            busy_q     <= busy_d;
            long_cnt_q <= long_cnt_d;
            dv_q       <= dv_d;
            insn_q     <= insn_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
        end
    end

    assign bus.fetch_retry     = bus.fetch_insn_valid && !(out_free && !hazard);
    assign bus.decode_valid    = dv_q;
    assign bus.decode_insn     = insn_q;
    assign bus.decode_pc       = pc_q;
    assign bus.decode_sign_ext = imm_q;
    assign bus.decode_src1     = src1_q;
    assign bus.decode_src2     = src2_q;
endmodule

// File: doc/decode_sb.md
Name: decode_sb

Overview:
- Parametrised decode stage; successor to the single-issue lab decode.
- Sits between fetch and execute. Owns the XLEN-wide integer register file and the immediate sign-extension.
- Adds a real valid/retry handshake on both sides, a per-register busy scoreboard, and an outstanding long-latency op counter.
- Presents a registered, hazard-free {insn, pc, imm, src1, src2} bundle to execute.

Parameters:
- XLEN, 64, datapath and register width; legal values 32 or 64.
- MAX_LONG, 4, maximum outstanding long-latency ops (loads, MUL/DIV); range 1..15.
- BYPASS, 1, 1 = writeback data forwarded into the operand capture in the same cycle; 0 = no forwarding.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_insn  in  32  instruction from fetch.
- fetch_pc  in  XLEN  PC of fetch_insn.
- fetch_insn_valid  in  1  fetch bundle valid.
- fetch_retry  out  1  1 = decode cannot take the bundle this cycle.
- decode_retry  in  1  1 = execute cannot take the output bundle.
- decode_valid  out  1  output bundle valid.
- decode_insn  out  32  instruction.
- decode_pc  out  XLEN  PC.
- decode_sign_ext  out  XLEN  sign-extended immediate.
- decode_src1  out  XLEN  rs1 value.
- decode_src2  out  XLEN  rs2 value.
- dest_valid  in  1  writeback strobe from execute.
- dest_long  in  1  writeback belongs to a long-latency op.
- dest_rd  in  5  writeback register index.
- dest  in  XLEN  writeback data.

Behaviour:
- Reset (reset=0, async):
  - all 32 registers = 0; busy[31:0] = 0; long_cnt = 0.
  - decode_valid = 0; all decode_* data outputs = 0.
- Decode classes, by opcode insn[6:0]:
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32, OP-32.
  - uses_rs1: everything except LUI, AUIPC, JAL.
  - uses_rs2: BRANCH, STORE, OP, OP-32.
  - is_long: LOAD, or (OP/OP-32 with funct7 = 0000001).
- Immediate:
  - I-type for LOAD, OP-IMM, OP-IMM-32, JALR; S-type for STORE; B-type for BRANCH; U-type for LUI, AUIPC; J-type for JAL.
  - All immediates are sign-extended from insn[31] to XLEN. Any other opcode gives 0.
- Hazard (combinational):
  - A source is blocked if it is used, its index is nonzero, busy[idx] = 1, and the same-cycle forward does not cover it (BYPASS=1 and dest_valid and dest_rd == idx).
  - rd is blocked if writes_rd and busy[rd] = 1 with no same-cycle clear of rd (WAW).
  - The long limit is hit if is_long and long_cnt == MAX_LONG and no dest_long completion arrives this cycle.
- Handshake:
  - out_free = !decode_valid | !decode_retry.
  - accept = fetch_insn_valid & out_free & !hazard.
  - fetch_retry = fetch_insn_valid & !(out_free & !hazard). fetch_retry is 0 when fetch is idle.
  - On accept, the output register loads the bundle on the next edge: latency 1 cycle, throughput 1 per cycle.
  - src values come from the register file; with BYPASS, dest overrides the file when dest_rd matches. x0 always reads 0.
  - If out_free and no accept, decode_valid -> 0. While decode_valid & decode_retry, all decode_* outputs hold stable.
- Scoreboard:
  - Issue is accept of an insn with writes_rd and rd != 0; it sets busy[rd].
  - dest_valid with dest_rd != 0 writes the register file and clears busy[dest_rd].
  - Set and clear on the same rd in the same cycle: set wins, and the write still occurs.
  - Writeback to x0 is ignored.
  - A writeback never modifies the held output bundle. Operands are final at capture.
- long_cnt:
  - +1 on accept of an is_long insn; -1 on dest_valid & dest_long.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_LONG. A decrement at 0 is a protocol error: the counter saturates at 0.
- XLEN=32: all PC and data paths are 32 bits. Sign extension is to 32 bits.

Test Plan:
- Reset, then ADDI x1,x0,-5 at pc 0x100, execute ready -> one cycle later decode_valid=1, decode_sign_ext=0xFFFF_FFFF_FFFF_FFFB, src1=0, decode_pc=0x100; busy[1]=1.
- Then ADD x2,x1,x1 -> fetch_retry=1 until dest_valid, dest_rd=1, dest=7. With BYPASS=1 it is accepted that same cycle, giving src1=src2=7. With BYPASS=0 it is accepted on the next cycle.
- decode_retry held high 3 cycles with a valid output and fetch presenting a new insn -> outputs stable, fetch_retry=1 throughout. Release -> next bundle appears 1 cycle later with no loss or duplication.
- MAX_LONG=2: three independent LD ops back-to-back -> third stalls. dest_valid & dest_long in a later cycle lets it accept in that same cycle. long_cnt sequence is 1, 2, 2, 2.
- Immediates: SW imm=-4, BEQ offset=-8, JAL offset=+2048, LUI 0xABCDE -> sign_ext = -4, -8, 0x800, 0xFFFF_FFFF_ABCD_E000.
- reset asserted mid-stall with busy bits set -> immediately decode_valid=0, busy=0, long_cnt=0, registers read 0 after release.
